// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB stream controller: host command opcodes,
// FSM state encoding and command-word field helpers.
// Command word layout: [31:24] opcode, [23:0] argument.
//   START  arg = frame target (0 = unlimited)
//   STOP   arg ignored
//   WRREG  [23:16] register address, [15:0] register data
package usb_cmd_pkg;

  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_STOP  = 8'h02;
  localparam logic [7:0] OP_WRREG = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DECODE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  function automatic logic [7:0] cmd_op(input logic [31:0] word);
    return word[31:24];
  endfunction

  function automatic logic [23:0] cmd_arg(input logic [31:0] word);
    return word[23:0];
  endfunction

  function automatic logic [7:0] cmd_addr(input logic [31:0] word);
    return word[23:16];
  endfunction

  function automatic logic [15:0] cmd_data(input logic [31:0] word);
    return word[15:0];
  endfunction

endpackage

// File: rtl/usb_poll_timer.sv
// Poll interval timer for the streaming state.
// Counts 0..POLL_CYCLES-1 while enabled, wraps to 0 and flags expiry on the
// last count. A synchronous clear has priority over counting.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous reset, active-low
//   clr     in  synchronous clear of the count
//   en      in  count enable
//   expire  out high in the cycle the count sits at POLL_CYCLES-1 and en=1
module usb_poll_timer #(
  parameter int POLL_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  assign expire = en && (cnt_q == LAST);

  // NOTE: sequential state is always written with <=, so every register in
  // the design samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || expire) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/usb_stream_ctrl.sv
// Sequencer for the shared FT-style USB FIFO port.
// Idle: polls the port for 32-bit host commands and decodes them.
// Streaming: holds the port in write mode, yields it every POLL_CYCLES to
// look for new host commands, and counts completed frames.
// Ports:
//   clkusb          in  USB-side clock (posedge)
//   rst_n           in  asynchronous reset, active-low
//   rxf             in  FIFO status, 1 = no host data
//   usb_busy        in  usb_int busy
//   usb_data_rd     in  assembled host word
//   frame_done      in  1-cycle pulse per completed frame
//   usb_wr_en       out 1 = port in write (stream) mode
//   usb_start_read  out read request to usb_int
//   stream_en       out gate for the ADC data path
//   cfg_wr          out 1-cycle register write strobe
//   cfg_addr        out register address (valid with cfg_wr)
//   cfg_data        out register data (valid with cfg_wr)
//   o_streaming     out stream session active
//   o_frame_cnt     out frames completed this session (saturating)
//   o_cmd_err       out 1-cycle pulse on an unknown opcode
module usb_stream_ctrl
  import usb_cmd_pkg::*;
#(
  parameter int POLL_CYCLES = 4096,
  parameter int RD_TIMEOUT  = 16,
  parameter int CNT_W       = 24
) (
  input  logic              clkusb,
  input  logic              rst_n,
  input  logic              rxf,
  input  logic              usb_busy,
  input  logic [31:0]       usb_data_rd,
  input  logic              frame_done,
  output logic              usb_wr_en,
  output logic              usb_start_read,
  output logic              stream_en,
  output logic              cfg_wr,
  output logic [7:0]        cfg_addr,
  output logic [15:0]       cfg_data,
  output logic              o_streaming,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic              o_cmd_err
);

  localparam int RTW = $clog2(RD_TIMEOUT + 1);
  localparam logic [RTW-1:0] RD_LAST = RTW'(RD_TIMEOUT - 1);

  state_t           state_q, state_nx;
  logic [31:0]      cmd_q;
  logic [RTW-1:0]   rd_cnt_q;
  logic [CNT_W-1:0] target_q;
  logic             poll_expire;
  logic             target_hit;
  logic             rd_timeout;
  state_t           ret_state;

  // Where a finished read/decode goes back to depends on the session flag.
  assign ret_state  = o_streaming ? ST_STREAM : ST_IDLE;
  assign target_hit = (target_q != '0) && (o_frame_cnt >= target_q);
  assign rd_timeout = (rd_cnt_q == RD_LAST);

  usb_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk    (clkusb),
    .rst_n  (rst_n),
    .clr    (state_q != ST_STREAM),
    .en     (state_q == ST_STREAM),
    .expire (poll_expire)
  );

  always_ff @(posedge clkusb or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:    if (!rxf && !usb_busy) state_nx = ST_RD_REQ;
      ST_RD_REQ: begin
        if (usb_busy)        state_nx = ST_RD_WAIT;
        else if (rd_timeout) state_nx = ret_state;
      end
      ST_RD_WAIT: if (!usb_busy) state_nx = ST_DECODE;
      ST_DECODE: begin
        case (cmd_op(cmd_q))
          OP_START: state_nx = ST_STREAM;
          OP_STOP:  state_nx = ST_IDLE;
          default:  state_nx = ret_state;
        endcase
      end
      ST_STREAM: begin
        // Target completion outranks a coincident poll.
        if (target_hit)               state_nx = ST_DRAIN;
        else if (poll_expire && !rxf) state_nx = ST_DRAIN;
      end
      ST_DRAIN:   if (!usb_busy) state_nx = rxf ? ret_state : ST_RD_REQ;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Read-request timeout: counts cycles spent in RD_REQ without busy.
  always_ff @(posedge clkusb or negedge rst_n) begin
    if (!rst_n)                  rd_cnt_q <= '0;
    else if (state_q != ST_RD_REQ) rd_cnt_q <= '0;
    else                         rd_cnt_q <= rd_cnt_q + 1'b1;
  end

  // Port-direction outputs are registered from the next state, so they
  // change on the same edge the FSM moves and the two are never both 1.
  always_ff @(posedge clkusb or negedge rst_n) begin
    if (!rst_n) begin
      usb_wr_en      <= 1'b0;
      usb_start_read <= 1'b0;
      stream_en      <= 1'b0;
      cfg_wr         <= 1'b0;
      cfg_addr       <= '0;
      cfg_data       <= '0;
      o_streaming    <= 1'b0;
      o_frame_cnt    <= '0;
      o_cmd_err      <= 1'b0;
      cmd_q          <= '0;
      target_q       <= '0;
    end else begin
      usb_wr_en      <= (state_nx == ST_STREAM);
      usb_start_read <= (state_nx == ST_RD_REQ);
      cfg_wr         <= 1'b0;
      o_cmd_err      <= 1'b0;

      if (state_q == ST_RD_WAIT && !usb_busy) cmd_q <= usb_data_rd;

      // Frames are counted in any state while a session is open.
      if (o_streaming && frame_done && (o_frame_cnt != '1))
        o_frame_cnt <= o_frame_cnt + 1'b1;

      if (state_q == ST_DECODE) begin
        case (cmd_op(cmd_q))
          OP_START: begin
            o_frame_cnt <= '0;
            target_q    <= CNT_W'(cmd_arg(cmd_q));
            o_streaming <= 1'b1;
            stream_en   <= 1'b1;
          end
          OP_STOP: begin
            o_streaming <= 1'b0;
            stream_en   <= 1'b0;
          end
          OP_WRREG: begin
            cfg_wr   <= 1'b1;
            cfg_addr <= cmd_addr(cmd_q);
            cfg_data <= cmd_data(cmd_q);
          end
          default: o_cmd_err <= 1'b1;
        endcase
      end

      if (state_q == ST_STREAM && target_hit) begin
        o_streaming <= 1'b0;
        stream_en   <= 1'b0;
      end
    end
  end

endmodule
